// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the N-to-1 stream multiplexer.
package stream_mux_pkg;

    // Selection mode driven on the mode port.
    typedef enum logic {
        MODE_SELECT = 1'b0,
        MODE_RR     = 1'b1
    } mode_e;

    // Upper bound on channel count supported by the index helper.
    localparam int MAX_N = 256;

    // Convert a one-hot vector to its bit index; an all-zero vector yields 0.
    function automatic int unsigned onehot_to_idx(input logic [MAX_N-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/stream_mux_nx1_rr_arbiter.sv
// Combinational round-robin arbiter: first requester above 'last', wrapping.
import stream_mux_pkg::*;

module rr_arbiter #(
    parameter int N     = 16,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic found;

    // Walk the N channels starting just above 'last'; the first requester wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req[(int'(last) + k) % N]) begin
                grant[(int'(last) + k) % N] = 1'b1;
                found = 1'b1;
            end
        end
    end

    assign grant_idx = SEL_W'(onehot_to_idx(MAX_N'(grant)));

endmodule

// File: rtl/stream_mux_nx1.sv
// N-to-1 valid/ready stream mux with SELECT and round-robin modes and a
// one-entry registered output buffer.
import stream_mux_pkg::*;

module stream_mux_nx1 #(
    parameter int N     = 16,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_chan,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [SEL_W-1:0] last;
    logic [N-1:0]     rr_grant;
    logic [SEL_W-1:0] rr_idx;
    logic [N-1:0]     sel_grant;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] grant_idx;
    logic             load;
    logic             xfer;
    logic             is_rr;

    rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
        .req       (in_valid),
        .last      (last),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    // SELECT grant: only the addressed channel, and only if it exists and is valid.
    always_comb begin
        sel_grant = '0;
        if (int'(sel) < N) sel_grant[sel] = in_valid[sel];
    end

    assign is_rr     = (mode_e'(mode) == MODE_RR);
    assign grant     = is_rr ? rr_grant : sel_grant;
    assign grant_idx = SEL_W'(onehot_to_idx(MAX_N'(grant)));
    assign load      = !out_valid || out_ready;
    // No handshake may complete while reset is asserted.
    assign in_ready  = (load && !rst) ? grant : '0;
    assign xfer      = |in_ready;

    // Output buffer: load on transfer, clear valid on an empty load slot,
    // hold everything under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            last      <= SEL_W'(N - 1);
        end else if (load) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(grant_idx)*W +: W];
                out_chan  <= grant_idx;
                if (is_rr) last <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Self-checking bench for stream_mux_nx1: directed scenarios plus random
// traffic, all compared against a transaction-level reference model.
module tb_stream_mux_nx1;

    localparam int N     = 16;
    localparam int W     = 8;
    localparam int SEL_W = $clog2(N);

    logic             clk;
    logic             rst;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_chan;
    logic             out_valid;
    logic             out_ready;

    stream_mux_nx1 #(.N(N), .W(W), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: contents of the output buffer and RR pointer.
    int m_valid = 0;
    int m_data  = 0;
    int m_chan  = 0;
    int m_last  = N - 1;

    logic [W-1:0] dat [N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Which channel the rules pick this cycle, or -1 for none.
    function automatic int pick(input logic md, input int s, input logic [N-1:0] v, input int lst);
        if (md == 1'b0) return (s < N && v[s]) ? s : -1;
        for (int k = 1; k <= N; k++) begin
            if (v[(lst + k) % N]) return (lst + k) % N;
        end
        return -1;
    endfunction

    // One clock: drive, check combinational ready and registered outputs,
    // then advance both DUT and model across the edge.
    task automatic step(input logic r, input logic md, input int s,
                        input logic [N-1:0] v, input logic ordy,
                        output logic [N-1:0] rdy_seen);
        int p;
        int nv, nd, nc, nl;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        rst = r; mode = md; sel = SEL_W'(s); in_valid = v; out_ready = ordy;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = dat[i];
        #1;
        p = pick(md, s, v, m_last);
        exp_rdy = '0;
        if (!r && p >= 0 && (m_valid == 0 || ordy)) exp_rdy[p] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid != 0) begin
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_chan", 32'(out_chan), 32'(m_chan));
        end
        rdy_seen = in_ready;
        nv = m_valid; nd = m_data; nc = m_chan; nl = m_last;
        if (r) begin
            nv = 0; nd = 0; nc = 0; nl = N - 1;
        end else if (m_valid == 0 || ordy) begin
            if (p >= 0) begin
                nv = 1; nd = int'(dat[p]); nc = p;
                if (md) nl = p;
            end else begin
                nv = 0;
            end
        end
        @(posedge clk);
        #2;
        m_valid = nv; m_data = nd; m_chan = nc; m_last = nl;
    endtask

    logic [N-1:0] rdy;
    logic [W-1:0] held_data;
    logic [SEL_W-1:0] held_chan;

    initial begin
        for (int i = 0; i < N; i++) dat[i] = W'($urandom);
        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b1; in_data = '0;
        @(posedge clk);
        // Second reset cycle with traffic present: nothing may be accepted.
        step(1'b1, 1'b1, 0, '1, 1'b1, rdy);
        chk("rst_ready", 32'(rdy), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_chan", 32'(out_chan), 32'h0);

        // SELECT channel 5.
        dat[5] = 8'hA5;
        step(1'b0, 1'b0, 5, 16'h0020, 1'b1, rdy);
        chk("sel5_ready", 32'(rdy), 32'h0020);
        chk("sel5_data", 32'(out_data), 32'hA5);
        chk("sel5_chan", 32'(out_chan), 32'd5);
        chk("sel5_valid", 32'(out_valid), 32'd1);

        // SELECT an idle channel while another is valid.
        step(1'b0, 1'b0, 3, 16'h0080, 1'b1, rdy);
        chk("sel3_ready", 32'(rdy), 32'h0);
        chk("sel3_valid", 32'(out_valid), 32'h0);

        // Round-robin fairness with every channel valid.
        for (int i = 0; i < N; i++) dat[i] = W'(i);
        for (int k = 0; k <= N; k++) begin
            step(1'b0, 1'b1, 0, '1, 1'b1, rdy);
            chk("rr_seq_chan", 32'(out_chan), 32'(k % N));
            chk("rr_seq_data", 32'(out_data), 32'(k % N));
        end

        // Backpressure: three stalled cycles keep the word and block inputs.
        held_data = out_data; held_chan = out_chan;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 0, '1, 1'b0, rdy);
            chk("bp_ready", 32'(rdy), 32'h0);
            chk("bp_data", 32'(out_data), 32'(held_data));
            chk("bp_chan", 32'(out_chan), 32'(held_chan));
        end
        step(1'b0, 1'b1, 0, 16'h0004, 1'b1, rdy);
        chk("bp_refill_ready", 32'(rdy), 32'h0004);
        chk("bp_refill_chan", 32'(out_chan), 32'd2);
        chk("bp_refill_valid", 32'(out_valid), 32'd1);

        // RR wrap/skip from last=14 with channels 3 and 9 valid.
        step(1'b0, 1'b1, 0, 16'h4000, 1'b1, rdy);
        chk("rr_set14", 32'(out_chan), 32'd14);
        step(1'b0, 1'b1, 0, 16'h0208, 1'b1, rdy);
        chk("rr_wrap_a", 32'(out_chan), 32'd3);
        step(1'b0, 1'b1, 0, 16'h0208, 1'b1, rdy);
        chk("rr_wrap_b", 32'(out_chan), 32'd9);
        step(1'b0, 1'b1, 0, 16'h0208, 1'b1, rdy);
        chk("rr_wrap_c", 32'(out_chan), 32'd3);

        // Reset while a word is held under backpressure.
        step(1'b0, 1'b1, 0, 16'h0208, 1'b0, rdy);
        step(1'b1, 1'b1, 0, '1, 1'b0, rdy);
        chk("midrst_ready", 32'(rdy), 32'h0);
        chk("midrst_valid", 32'(out_valid), 32'h0);
        step(1'b0, 1'b1, 0, '1, 1'b1, rdy);
        chk("midrst_prio", 32'(out_chan), 32'd0);

        // Random traffic: modes, selects, valids, backpressure, rare resets.
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] v;
            for (int i = 0; i < N; i++) dat[i] = W'($urandom);
            v = N'($urandom) & N'($urandom);
            step(($urandom_range(0, 40) == 0), 1'($urandom), int'($urandom_range(0, N - 1)),
                 v, ($urandom_range(0, 3) != 0), rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
